// File: rtl/decode_hazard_ctrl.sv
// decode_hazard_ctrl
// Decode-stage hazard controller. A per-register counter tracks how many
// issued-but-not-yet-written-back instructions target each register. Each
// cycle the instruction in IF/ID either issues, or is held while a bubble is
// loaded into ID/EX.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   id_valid, id_inst IF/ID buffer contents
//   ex_ready          ID/EX can accept this cycle
//   flush             kill the instruction in ID
//   WE, wb_addr       register-file write port seen at writeback
//   issue             ID instruction moves to ID/EX this cycle
//   stall             hold PC and IF/ID
//   bubble            load a NOP into ID/EX
//   pending           bit i set while register i has outstanding writes
//   stall_cycles      saturating count of stalled cycles
//   err               sticky: writeback to a register with nothing outstanding
module decode_hazard_ctrl #(
  parameter int NREG  = 32,
  parameter int CNT_W = 2,
  parameter int SC_W  = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [31:0]     id_inst,
  input  logic            ex_ready,
  input  logic            flush,
  input  logic            WE,
  input  logic [4:0]      wb_addr,
  output logic            issue,
  output logic            stall,
  output logic            bubble,
  output logic [NREG-1:0] pending,
  output logic [SC_W-1:0] stall_cycles,
  output logic            err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_q [NREG];
  logic [CNT_W-1:0] cnt_d [NREG];
  logic [SC_W-1:0]  sc_q, sc_d;
  logic             err_q, err_d;

  logic [5:0] opcode;
  logic [4:0] rs, rt, rd;
  logic       rd_a, rd_b, wr_en;
  logic [4:0] wr_addr;
  logic       raw, full, hazard, err_set;
  logic [NREG-1:0] inc_hit, wb_hit;

  assign opcode = id_inst[31:26];
  assign rs     = id_inst[25:21];
  assign rt     = id_inst[20:16];
  assign rd     = id_inst[15:11];

  always_comb begin
    rd_a    = 1'b0;
    rd_b    = 1'b0;
    wr_en   = 1'b0;
    wr_addr = rt;
    case (opcode)
      6'h00: begin
        rd_a    = 1'b1;
        rd_b    = 1'b1;
        wr_en   = 1'b1;
        wr_addr = rd;
      end
      6'h23, 6'h08, 6'h0C, 6'h0D, 6'h0A: begin
        rd_a  = 1'b1;
        wr_en = 1'b1;
      end
      6'h2B, 6'h04, 6'h05: begin
        rd_a = 1'b1;
        rd_b = 1'b1;
      end
      6'h02: ;
      default: rd_a = 1'b1;
    endcase
  end

  // Register 0 never tracks anything, so it can never be a hazard source.
  assign raw    = (rd_a && rs != 5'd0 && cnt_q[rs] != '0) ||
                  (rd_b && rt != 5'd0 && cnt_q[rt] != '0);
  assign full   = wr_en && wr_addr != 5'd0 && cnt_q[wr_addr] == CNT_MAX;
  assign hazard = raw || full;

  assign issue  = !rst && id_valid && !flush && !hazard && ex_ready;
  assign stall  = !rst && id_valid && !flush && (hazard || !ex_ready);
  assign bubble = !rst && ex_ready && !issue;

  assign inc_hit = (issue && wr_en && wr_addr != 5'd0) ? (NREG'(1) << wr_addr) : '0;
  assign wb_hit  = (WE && wb_addr != 5'd0) ? (NREG'(1) << wb_addr) : '0;

  // An issue and a writeback to the same register cancel; a writeback with
  // nothing outstanding (and no cancelling issue) flags an error.
  always_comb begin
    err_set = 1'b0;
    for (int r = 0; r < NREG; r++) begin
      cnt_d[r] = cnt_q[r];
      if (inc_hit[r] && !wb_hit[r]) begin
        cnt_d[r] = cnt_q[r] + CNT_W'(1);
      end else if (wb_hit[r] && !inc_hit[r]) begin
        if (cnt_q[r] != '0) cnt_d[r] = cnt_q[r] - CNT_W'(1);
        else                err_set  = 1'b1;
      end
    end
  end

  always_comb begin
    for (int r = 0; r < NREG; r++) pending[r] = (cnt_q[r] != '0);
  end

  always_comb begin
    sc_d = sc_q;
    if (stall && sc_q != '1) sc_d = sc_q + SC_W'(1);
  end

  assign err_d = err_q || err_set;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) cnt_q[r] <= '0;
      sc_q  <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sc_q  <= sc_d;
      err_q <= err_d;
    end
  end

  assign stall_cycles = sc_q;
  assign err          = err_q;

endmodule

// File: tb/tb_decode_hazard_ctrl.sv
module tb_decode_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst, id_valid, ex_ready, flush, WE;
  logic [31:0] id_inst;
  logic [4:0]  wb_addr;
  logic        issue, stall, bubble, err;
  logic [31:0] pending;
  logic [15:0] stall_cycles;

  always #5 clk = ~clk;

  decode_hazard_ctrl dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_inst(id_inst),
    .ex_ready(ex_ready), .flush(flush), .WE(WE), .wb_addr(wb_addr),
    .issue(issue), .stall(stall), .bubble(bubble), .pending(pending),
    .stall_cycles(stall_cycles), .err(err)
  );

  typedef struct packed {
    logic        issue;
    logic        stall;
    logic        bubble;
    logic [31:0] pending;
    logic [15:0] sc;
    logic        err;
    logic        known;
  } exp_t;

  exp_t expq[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  // Reference model: in-flight write count per register, plain integers.
  int cnt[32];
  int m_sc    = 0;
  bit m_err   = 0;
  bit m_known = 0;

  function automatic void decode(input logic [31:0] inst, output bit ra, output bit rb,
                                 output bit wr, output int wreg);
    int op;
    op   = int'(inst[31:26]);
    ra   = 1; rb = 0; wr = 0;
    wreg = int'(inst[20:16]);
    if (op == 'h00) begin
      rb = 1; wr = 1; wreg = int'(inst[15:11]);
    end else if (op == 'h23 || op == 'h08 || op == 'h0C || op == 'h0D || op == 'h0A) begin
      wr = 1;
    end else if (op == 'h2B || op == 'h04 || op == 'h05) begin
      rb = 1;
    end else if (op == 'h02) begin
      ra = 0;
    end
  endfunction

  task automatic drive(input bit r, input bit v, input logic [31:0] inst, input bit er,
                       input bit fl, input bit we, input int wa);
    exp_t e;
    bit ra, rb, wr, haz, wb;
    int wreg, rs, rt, inc;
    @(posedge clk);
    #1;
    rst = r; id_valid = v; id_inst = inst; ex_ready = er; flush = fl;
    WE = we; wb_addr = wa[4:0];
    decode(inst, ra, rb, wr, wreg);
    rs  = int'(inst[25:21]);
    rt  = int'(inst[20:16]);
    haz = (ra && rs != 0 && cnt[rs] > 0) || (rb && rt != 0 && cnt[rt] > 0) ||
          (wr && wreg != 0 && cnt[wreg] == 3);
    e.issue  = !r && v && !fl && !haz && er;
    e.stall  = !r && v && !fl && (haz || !er);
    e.bubble = !r && er && !e.issue;
    for (int i = 0; i < 32; i++) e.pending[i] = (cnt[i] > 0);
    e.sc    = m_sc[15:0];
    e.err   = m_err;
    e.known = m_known;
    expq.push_back(e);
    if (r) begin
      for (int i = 0; i < 32; i++) cnt[i] = 0;
      m_sc = 0; m_err = 0; m_known = 1;
    end else begin
      inc = (e.issue && wr && wreg != 0) ? wreg : 0;
      wb  = we && wa != 0;
      if (!(inc != 0 && wb && wa == inc)) begin
        if (inc != 0) cnt[inc]++;
        if (wb) begin
          if (cnt[wa] > 0) cnt[wa]--;
          else             m_err = 1;
        end
      end
      if (e.stall && m_sc < 65535) m_sc++;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (expq.size() != 0) begin
      e = expq.pop_front();
      chk("issue",  {31'd0, issue},  {31'd0, e.issue});
      chk("stall",  {31'd0, stall},  {31'd0, e.stall});
      chk("bubble", {31'd0, bubble}, {31'd0, e.bubble});
      if (e.known) begin
        chk("pending",      pending,               e.pending);
        chk("stall_cycles", {16'd0, stall_cycles}, {16'd0, e.sc});
        chk("err",          {31'd0, err},          {31'd0, e.err});
      end
    end
  end

  localparam logic [31:0] ADD3 = 32'h00221820;  // add $3,$1,$2
  localparam logic [31:0] SUB4 = 32'h00612022;  // sub $4,$3,$1
  localparam logic [31:0] LW5  = 32'h8C050000;  // lw $5,0($0)
  localparam logic [31:0] LW7  = 32'h8C070000;  // lw $7,0($0)
  localparam logic [31:0] ADD0 = 32'h00220020;  // add $0,$1,$2

  function automatic logic [31:0] rand_inst();
    logic [5:0] ops [8];
    ops[0] = 6'h00; ops[1] = 6'h23; ops[2] = 6'h08; ops[3] = 6'h2B;
    ops[4] = 6'h04; ops[5] = 6'h02; ops[6] = 6'h3F; ops[7] = 6'h0D;
    return {ops[$urandom_range(7)], 5'($urandom_range(7)), 5'($urandom_range(7)),
            5'($urandom_range(7)), 11'($urandom)};
  endfunction

  initial begin
    int pend_list[$];
    int wa;
    rst = 1; id_valid = 1; id_inst = '0; ex_ready = 1; flush = 0; WE = 0; wb_addr = '0;

    // Reset with live-looking inputs.
    drive(1, 1, rand_inst(), 1'($urandom), 0, 1'($urandom), $urandom_range(31));
    drive(1, 1, rand_inst(), 1'($urandom), 0, 1'($urandom), $urandom_range(31));
    drive(0, 0, 0, 1, 0, 0, 0);

    // RAW stall released one cycle after the writeback edge.
    drive(0, 1, ADD3, 1, 0, 0, 0);
    repeat (3) drive(0, 1, SUB4, 1, 0, 0, 0);
    drive(0, 1, SUB4, 1, 0, 1, 3);
    drive(0, 1, SUB4, 1, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 1, 4);

    // Counter saturation on $5.
    repeat (3) drive(0, 1, LW5, 1, 0, 0, 0);
    repeat (2) drive(0, 1, LW5, 1, 0, 0, 0);
    drive(0, 1, LW5, 1, 0, 1, 5);
    drive(0, 1, LW5, 1, 0, 0, 0);
    repeat (3) drive(0, 0, 0, 1, 0, 1, 5);

    // Issue and writeback to $7 in the same cycle.
    drive(0, 1, LW7, 1, 0, 0, 0);
    drive(0, 1, LW7, 1, 0, 1, 7);
    drive(0, 0, 0, 1, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 1, 7);

    // Zero destination, then writeback to an idle register.
    drive(0, 1, ADD0, 1, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 1, 0);
    drive(0, 0, 0, 1, 0, 1, 9);
    repeat (3) drive(0, 0, 0, 1, 0, 0, 0);
    drive(1, 0, 0, 1, 0, 0, 0);

    // Flush during a RAW stall, then back-pressure without a hazard.
    drive(0, 1, ADD3, 1, 0, 0, 0);
    drive(0, 1, SUB4, 1, 0, 0, 0);
    drive(0, 1, SUB4, 1, 1, 0, 0);
    drive(0, 1, SUB4, 1, 0, 1, 3);
    drive(0, 1, ADD0, 0, 0, 0, 0);
    drive(0, 1, ADD0, 0, 0, 0, 0);

    // Reset in the middle of a stall drops tracking.
    drive(0, 1, ADD3, 1, 0, 0, 0);
    drive(0, 1, SUB4, 1, 0, 0, 0);
    drive(1, 1, SUB4, 1, 0, 0, 0);
    drive(0, 1, SUB4, 1, 0, 0, 0);

    // Random traffic, writebacks steered mostly at outstanding registers.
    for (int n = 0; n < 3000; n++) begin
      pend_list.delete();
      for (int i = 1; i < 8; i++) if (cnt[i] > 0) pend_list.push_back(i);
      if (pend_list.size() != 0 && $urandom_range(9) != 0)
        wa = pend_list[$urandom_range(pend_list.size() - 1)];
      else
        wa = $urandom_range(9);
      drive(($urandom_range(199) == 0), ($urandom_range(3) != 0), rand_inst(),
            ($urandom_range(5) != 0), ($urandom_range(11) == 0),
            ($urandom_range(9) < 4), wa);
    end
    drive(0, 0, 0, 1, 0, 0, 0);

    repeat (3) @(negedge clk);
    if (expq.size() != 0) begin
      n_chk++;
      $display("FAIL drain: %0d expected responses left, expected 0", expq.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
